// File: rtl/mu0_control_if.sv
// mu0_control_if: control bundle between the MU0 control FSM and its datapath/memory
interface mu0_control_if;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       MemRdy;
    logic       Addr_sel;
    logic       X_sel;
    logic       Y_sel;
    logic [1:0] ALU_fs;
    logic       Acc_ce;
    logic       PC_ce;
    logic       IR_ce;
    logic       Rd;
    logic       Wr;
    logic       Halted;
    logic       Fault;
    logic [1:0] State;

    modport master (
        input  F, N, Z, MemRdy,
        output Addr_sel, X_sel, Y_sel, ALU_fs, Acc_ce, PC_ce, IR_ce, Rd, Wr, Halted, Fault, State
    );

    modport slave (
        output F, N, Z, MemRdy,
        input  Addr_sel, X_sel, Y_sel, ALU_fs, Acc_ce, PC_ce, IR_ce, Rd, Wr, Halted, Fault, State
    );
endinterface

// File: rtl/mu0_control.sv
// mu0_control: fetch/execute control FSM for the MU0 accumulator processor with memory-wait timeout
module mu0_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic          Clk,
    input logic          nReset,
    mu0_control_if.master bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] EXEC  = 2'b10;
    localparam logic [1:0] HALT  = 2'b11;

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          mem_state, timeout;

    // FETCH and the load/store/arithmetic opcodes are the only states that touch memory
    assign mem_state = (state_q == FETCH) || (state_q == EXEC && bus.F[3:2] == 2'b00);
    assign timeout   = (MEM_TIMEOUT > 0) && mem_state && !bus.MemRdy && (cnt_q == TO_LAST);

    // next state, wait counter and sticky fault
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: state_d = bus.MemRdy ? EXEC : (timeout ? HALT : FETCH);
            EXEC:  state_d = bus.F[3]          ? HALT :
                             (bus.F == 4'd7)    ? HALT :
                             bus.F[2]           ? FETCH :
                             bus.MemRdy         ? FETCH :
                             timeout            ? HALT : EXEC;
            default: state_d = HALT;
        endcase
        cnt_d   = (mem_state && !bus.MemRdy && !timeout) ? cnt_q + 1'b1 : '0;
        fault_d = fault_q || timeout || (state_q == EXEC && bus.F[3]);
    end

    // state registers, cleared asynchronously
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // datapath selects, enables and strobes decoded from the current state and opcode
    always_comb begin
        bus.Addr_sel = 1'b0;
        bus.X_sel    = 1'b0;
        bus.Y_sel    = 1'b0;
        bus.ALU_fs   = 2'b00;
        bus.Acc_ce   = 1'b0;
        bus.PC_ce    = 1'b0;
        bus.IR_ce    = 1'b0;
        bus.Rd       = 1'b0;
        bus.Wr       = 1'b0;
        bus.Halted   = (state_q == HALT);
        bus.Fault    = fault_q;
        bus.State    = state_q;
        case (state_q)
            FETCH: begin
                bus.Rd     = 1'b1;
                bus.X_sel  = 1'b1;
                bus.ALU_fs = 2'b10;
                bus.IR_ce  = bus.MemRdy;
                bus.PC_ce  = bus.MemRdy;
            end
            EXEC: begin
                case (bus.F)
                    4'd0: begin
                        bus.Addr_sel = 1'b1;
                        bus.Rd       = 1'b1;
                        bus.Acc_ce   = bus.MemRdy;
                    end
                    4'd1: begin
                        bus.Addr_sel = 1'b1;
                        bus.Wr       = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        bus.Addr_sel = 1'b1;
                        bus.Rd       = 1'b1;
                        bus.ALU_fs   = bus.F[0] ? 2'b11 : 2'b01;
                        bus.Acc_ce   = bus.MemRdy;
                    end
                    4'd4, 4'd5, 4'd6: begin
                        bus.Y_sel = 1'b1;
                        bus.PC_ce = (bus.F == 4'd4) ? 1'b1 : (bus.F == 4'd5) ? ~bus.N : ~bus.Z;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: table-driven cycle-by-cycle check of the MU0 control FSM
module tb_mu0_control;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int checks = 0;
    int failures = 0;

    mu0_control_if bus();

    mu0_control #(.MEM_TIMEOUT(4)) dut (
        .Clk    (clk),
        .nReset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] f;
        logic       n;
        logic       z;
        logic       rdy;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] o(input logic a, x, y, input logic [1:0] fs,
                                      input logic acc, pc, ir, rd, wr, h, flt, input logic [1:0] st);
        return {a, x, y, fs, acc, pc, ir, rd, wr, h, flt, st};
    endfunction

    function automatic logic [13:0] got();
        return {bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.ALU_fs, bus.Acc_ce, bus.PC_ce,
                bus.IR_ce, bus.Rd, bus.Wr, bus.Halted, bus.Fault, bus.State};
    endfunction

    task automatic add(input bit rst, input logic [3:0] f, input logic n, z, rdy, input logic [13:0] exp);
        vec_t v;
        v.rst = rst; v.f = f; v.n = n; v.z = z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 nreset = 1'b0;
        #2;
        checks++;
        if (got() !== 14'h0) begin
            failures++;
            $display("FAIL reset_async got=%b required=%b", got(), 14'h0);
        end
        @(posedge clk);
        #1 nreset = 1'b1;
    endtask

    initial begin
        logic [13:0] idle, fe1, fe0, lda1, add1, sub0, sub1, jmp0, jmp1, sta, stp, halt0, halt1;
        idle  = 14'h0;
        fe1   = o(0,1,0,2'b10,0,1,1,1,0,0,0,2'd1);
        fe0   = o(0,1,0,2'b10,0,0,0,1,0,0,0,2'd1);
        lda1  = o(1,0,0,2'b00,1,0,0,1,0,0,0,2'd2);
        add1  = o(1,0,0,2'b01,1,0,0,1,0,0,0,2'd2);
        sub0  = o(1,0,0,2'b11,0,0,0,1,0,0,0,2'd2);
        sub1  = o(1,0,0,2'b11,1,0,0,1,0,0,0,2'd2);
        jmp0  = o(0,0,1,2'b00,0,0,0,0,0,0,0,2'd2);
        jmp1  = o(0,0,1,2'b00,0,1,0,0,0,0,0,2'd2);
        sta   = o(1,0,0,2'b00,0,0,0,0,1,0,0,2'd2);
        stp   = o(0,0,0,2'b00,0,0,0,0,0,0,0,2'd2);
        halt0 = o(0,0,0,2'b00,0,0,0,0,0,1,0,2'd3);
        halt1 = o(0,0,0,2'b00,0,0,0,0,0,1,1,2'd3);
        // run A: LDA, ADD, SUB with a wait, jumps, fetch stall, STA timeout
        add(1, 4'd0, 0, 0, 1, idle);
        add(0, 4'd0, 0, 0, 1, fe1);
        add(0, 4'd0, 0, 0, 1, lda1);
        add(0, 4'd2, 0, 0, 1, fe1);
        add(0, 4'd2, 0, 0, 1, add1);
        add(0, 4'd3, 0, 0, 1, fe1);
        add(0, 4'd3, 0, 0, 0, sub0);
        add(0, 4'd3, 0, 0, 1, sub1);
        add(0, 4'd5, 1, 0, 1, fe1);
        add(0, 4'd5, 1, 0, 0, jmp0);
        add(0, 4'd5, 0, 0, 0, fe0);
        add(0, 4'd5, 0, 0, 0, fe0);
        add(0, 4'd5, 0, 0, 0, fe0);
        add(0, 4'd5, 0, 0, 1, fe1);
        add(0, 4'd5, 0, 0, 1, jmp1);
        add(0, 4'd6, 0, 1, 1, fe1);
        add(0, 4'd6, 0, 1, 1, jmp0);
        add(0, 4'd6, 0, 0, 1, fe1);
        add(0, 4'd6, 0, 0, 1, jmp1);
        add(0, 4'd4, 1, 1, 1, fe1);
        add(0, 4'd4, 1, 1, 0, jmp1);
        add(0, 4'd1, 0, 0, 1, fe1);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 0, halt1);
        add(0, 4'd0, 0, 0, 1, halt1);
        // run B: STA completes on the last allowed cycle, then STP
        add(1, 4'd1, 0, 0, 1, idle);
        add(0, 4'd1, 0, 0, 1, fe1);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 0, sta);
        add(0, 4'd1, 0, 0, 1, sta);
        add(0, 4'd7, 0, 0, 1, fe1);
        add(0, 4'd7, 0, 0, 1, stp);
        add(0, 4'd7, 0, 0, 1, halt0);
        // run E: stopped mid-STA by the next reset
        add(1, 4'd1, 0, 0, 1, idle);
        add(0, 4'd1, 0, 0, 1, fe1);
        add(0, 4'd1, 0, 0, 0, sta);
        // run C: illegal opcode
        add(1, 4'd9, 0, 0, 1, idle);
        add(0, 4'd9, 0, 0, 1, fe1);
        add(0, 4'd9, 0, 0, 1, stp);
        add(0, 4'd9, 0, 0, 1, halt1);
        // run D: fetch timeout
        add(1, 4'd0, 0, 0, 0, idle);
        add(0, 4'd0, 0, 0, 0, fe0);
        add(0, 4'd0, 0, 0, 0, fe0);
        add(0, 4'd0, 0, 0, 0, fe0);
        add(0, 4'd0, 0, 0, 0, fe0);
        add(0, 4'd0, 0, 0, 1, halt1);
        bus.F = 4'd0; bus.N = 1'b0; bus.Z = 1'b0; bus.MemRdy = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            bus.F = vecs[i].f; bus.N = vecs[i].n; bus.Z = vecs[i].z; bus.MemRdy = vecs[i].rdy;
            @(negedge clk);
            checks++;
            if (got() !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d got=%b required=%b", i, got(), vecs[i].exp);
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
